// File: rtl/w5300_bus_arbiter_pkg.sv
// Shared W5300 host-bus definitions: access field widths, the priority requester
// index and the arbiter state encoding.
package w5300_bus_arbiter_pkg;

  localparam int W5300_ADDR_W = 10;
  localparam int W5300_DATA_W = 16;
  localparam int REQ_IRQ      = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/w5300_rr_pick.sv
// Combinational owner picker: the IRQ requester wins outright, otherwise
// round-robin over requesters 1..NUM_REQ-1 starting after last_rr.
module w5300_rr_pick
  import w5300_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_rr,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int unsigned N = NUM_REQ;

  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    cand  = '0;
    if (req[REQ_IRQ]) begin
      gnt[REQ_IRQ] = 1'b1;
    end else begin
      // Candidates wrap within 1..N-1; last_rr = 0 (reset) starts the scan at 1.
      for (int unsigned o = 1; o < N; o++) begin
        cand = {1'b0, last_rr} + (IDX_W+1)'(o);
        if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N - 1);
        if (!found && req[cand[IDX_W-1:0]]) begin
          gnt[cand[IDX_W-1:0]] = 1'b1;
          found                = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/w5300_bus_arbiter.sv
// Arbiter in front of the single W5300 host-bus access engine: one register
// access at a time, IRQ requester on fixed priority, lockable ownership.
module w5300_bus_arbiter
  import w5300_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req,
  input  logic [NUM_REQ-1:0]                     req_lock,
  input  logic [NUM_REQ*(W5300_ADDR_W+1)-1:0]    req_addr,
  input  logic [NUM_REQ*W5300_DATA_W-1:0]        req_wr_data,
  output logic [NUM_REQ-1:0]                     gnt,
  output logic [NUM_REQ-1:0]                     done,
  output logic                                   err,
  output logic [W5300_DATA_W-1:0]                rd_data,
  output logic                                   bus_start,
  output logic [W5300_ADDR_W:0]                  bus_addr,
  output logic [W5300_DATA_W-1:0]                bus_wr_data,
  input  logic                                   bus_done,
  input  logic [W5300_DATA_W-1:0]                bus_rd_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int ENT_W = W5300_ADDR_W + 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t              state_q, state_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        last_rr_q, last_rr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    bus_start_q, bus_start_d;
  logic [ENT_W-1:0]        bus_addr_q, bus_addr_d;
  logic [W5300_DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    err_q, err_d;
  logic [W5300_DATA_W-1:0] rd_data_q, rd_data_d;

  logic [NUM_REQ-1:0]      pick_gnt;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W-1:0]        sel;
  logic                    load;

  w5300_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .last_rr (last_rr_q),
    .gnt     (pick_gnt)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) pick_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    owner_d       = owner_q;
    last_rr_d     = last_rr_q;
    cnt_d         = cnt_q;
    bus_start_d   = 1'b0;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    done_d        = '0;
    err_d         = 1'b0;
    rd_data_d     = rd_data_q;
    sel           = owner_q;
    load          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_q == '0) begin
          if (|req) begin
            gnt_d   = pick_gnt;
            owner_d = pick_idx;
            sel     = pick_idx;
            load    = 1'b1;
            state_d = ISSUE;
          end
        end else if (req[owner_q]) begin
          // Locked owner: issue straight from the hold so the next bus_start
          // lands two cycles after the previous done.
          load        = 1'b1;
          bus_start_d = 1'b1;
          cnt_d       = CNT_W'(TIMEOUT);
          state_d     = WAIT;
        end else if (!req_lock[owner_q]) begin
          gnt_d = '0;
        end
      end
      ISSUE: begin
        bus_start_d = 1'b1;
        cnt_d       = CNT_W'(TIMEOUT);
        state_d     = WAIT;
      end
      WAIT: begin
        if (bus_done) begin
          rd_data_d       = bus_rd_data;
          done_d[owner_q] = 1'b1;
          state_d         = DONE;
        end else if (cnt_q == '0) begin
          rd_data_d       = '0;
          done_d[owner_q] = 1'b1;
          err_d           = 1'b1;
          state_d         = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (!req_lock[owner_q]) begin
          gnt_d = '0;
          if (owner_q != IDX_W'(REQ_IRQ)) last_rr_d = owner_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      bus_addr_d    = req_addr[int'(sel)*ENT_W +: ENT_W];
      bus_wr_data_d = req_wr_data[int'(sel)*W5300_DATA_W +: W5300_DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      owner_q       <= '0;
      last_rr_q     <= '0;
      cnt_q         <= '0;
      bus_start_q   <= 1'b0;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      done_q        <= '0;
      err_q         <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      owner_q       <= owner_d;
      last_rr_q     <= last_rr_d;
      cnt_q         <= cnt_d;
      bus_start_q   <= bus_start_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      done_q        <= done_d;
      err_q         <= err_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rd_data     = rd_data_q;
  assign bus_start   = bus_start_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;

endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// Directed bench for w5300_bus_arbiter with a small in-bench access engine
// that answers each bus_start after a programmable latency.
module tb_w5300_bus_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ-1:0]     req_lock;
  logic [NUM_REQ*11-1:0]  req_addr;
  logic [NUM_REQ*16-1:0]  req_wr_data;
  logic [NUM_REQ-1:0]     gnt;
  logic [NUM_REQ-1:0]     done;
  logic                   err;
  logic [15:0]            rd_data;
  logic                   bus_start;
  logic [10:0]            bus_addr;
  logic [15:0]            bus_wr_data;
  logic                   bus_done;
  logic [15:0]            bus_rd_data;

  int          n_checks  = 0;
  int          n_pass    = 0;
  int          cyc       = 0;
  int          start_cnt = 0;
  int          start_cyc = 0;
  int          eng_cnt   = 0;
  int          eng_lat   = 3;
  int          dcyc      = 0;
  int          s0        = 0;
  logic        eng_on    = 1'b1;
  logic [15:0] eng_data  = '0;
  logic [3:0]  gnt_or    = '0;
  logic [3:0]  done_or   = '0;
  logic [3:0]  rr_exp [4];

  always #5 clk = ~clk;

  w5300_bus_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_lock    (req_lock),
    .req_addr    (req_addr),
    .req_wr_data (req_wr_data),
    .gnt         (gnt),
    .done        (done),
    .err         (err),
    .rd_data     (rd_data),
    .bus_start   (bus_start),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_done    (bus_done),
    .bus_rd_data (bus_rd_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One clock: sample after the edge, then step the engine model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    gnt_or  |= gnt;
    done_or |= done;
    bus_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        bus_done    = 1'b1;
        bus_rd_data = eng_data;
      end
    end
    if (bus_start) begin
      start_cnt++;
      start_cyc = cyc;
      if (eng_on) eng_cnt = eng_lat;
    end
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (|done) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic set_slot(input int i, input logic [10:0] a, input logic [15:0] d);
    req_addr[i*11 +: 11]    = a;
    req_wr_data[i*16 +: 16] = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = '0; req_lock = '0; req_addr = '0; req_wr_data = '0;
    bus_done = 1'b0; bus_rd_data = '0;
    rr_exp[0] = 4'b0010; rr_exp[1] = 4'b0100; rr_exp[2] = 4'b1000; rr_exp[3] = 4'b0010;
    tick(); tick();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_bus_start", 32'(bus_start), 0);
    check("rst_bus_addr", 32'(bus_addr), 0);
    check("rst_bus_wr_data", 32'(bus_wr_data), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    rst_n = 1'b1;
    tick();

    // Single read by requester 2, engine answers 3 cycles after bus_start
    set_slot(2, {1'b0, 10'h002}, 16'h0000);
    eng_data = 16'h0100; s0 = start_cnt;
    req[2] = 1'b1;
    tick();
    check("rd_gnt", 32'(gnt), 32'h4);
    check("rd_issue_no_start", 32'(bus_start), 0);
    tick();
    check("rd_start", 32'(bus_start), 1);
    check("rd_bus_addr", 32'(bus_addr), 32'h002);
    wait_done("rd");
    check("rd_done", 32'(done), 32'h4);
    check("rd_data", 32'(rd_data), 32'h0100);
    check("rd_err", 32'(err), 0);
    check("rd_latency", 32'(cyc - start_cyc), 4);
    check("rd_one_start", 32'(start_cnt - s0), 1);
    req[2] = 1'b0;
    tick();
    check("rd_release", 32'(gnt), 0);

    // Priority: requester 0 beats requester 1
    set_slot(0, {1'b0, 10'h002}, 16'h0000);
    set_slot(1, {1'b0, 10'h004}, 16'h0000);
    eng_data = 16'h1111;
    req[0] = 1'b1; req[1] = 1'b1;
    tick();
    check("pri_gnt0", 32'(gnt), 32'h1);
    wait_done("pri0");
    check("pri_done0", 32'(done), 32'h1);
    req[0] = 1'b0;
    tick();
    check("pri_idle_gap", 32'(gnt), 0);
    tick();
    check("pri_gnt1", 32'(gnt), 32'h2);
    wait_done("pri1");
    check("pri_done1", 32'(done), 32'h2);
    req[1] = 1'b0;
    tick();

    // Lock: requester 0 runs IR read, Sn_IR read, Sn_IR clear while req[3] waits
    set_slot(3, {1'b0, 10'h030}, 16'h0000);
    set_slot(0, {1'b0, 10'h002}, 16'h0000);
    eng_data = 16'h0081; gnt_or = '0;
    req_lock[0] = 1'b1; req[0] = 1'b1; req[3] = 1'b1;
    tick();
    check("lock_gnt", 32'(gnt), 32'h1);
    wait_done("lock1");
    check("lock1_rd", 32'(rd_data), 32'h0081);
    dcyc = cyc;
    set_slot(0, {1'b0, 10'h206}, 16'h0000);
    eng_data = 16'h0001;
    wait_done("lock2");
    check("lock2_gap", 32'(start_cyc - dcyc), 2);
    check("lock2_done", 32'(done), 32'h1);
    check("lock2_rd", 32'(rd_data), 32'h0001);
    dcyc = cyc;
    set_slot(0, {1'b1, 10'h206}, 16'h0004);
    wait_done("lock3");
    check("lock3_gap", 32'(start_cyc - dcyc), 2);
    check("lock3_bus_addr", 32'(bus_addr), 32'h606);
    check("lock3_wr_data", 32'(bus_wr_data), 32'h0004);
    check("lock_gnt_held", 32'(gnt_or), 32'h1);
    req_lock[0] = 1'b0; req[0] = 1'b0;
    tick();
    check("lock_release", 32'(gnt), 0);
    tick();
    check("lock_next_gnt3", 32'(gnt), 32'h8);
    wait_done("lock_r3");
    check("lock_done3", 32'(done), 32'h8);
    req[3] = 1'b0;
    tick();

    // Lock held while idle, then released by dropping req_lock
    set_slot(1, {1'b0, 10'h010}, 16'h0000);
    eng_data = 16'h5A5A;
    req_lock[1] = 1'b1; req[1] = 1'b1;
    tick();
    check("hold_gnt", 32'(gnt), 32'h2);
    wait_done("hold");
    check("hold_rd", 32'(rd_data), 32'h5A5A);
    req[1] = 1'b0;
    tick(); tick();
    check("hold_idle", 32'(gnt), 32'h2);
    req_lock[1] = 1'b0;
    tick();
    check("hold_release", 32'(gnt), 0);

    // Timeout: engine never answers
    eng_on = 1'b0;
    req[1] = 1'b1;
    wait_done("to");
    check("to_latency", 32'(cyc - start_cyc), TIMEOUT + 1);
    check("to_done", 32'(done), 32'h2);
    check("to_err", 32'(err), 1);
    check("to_rd_zero", 32'(rd_data), 0);
    req[1] = 1'b0; eng_on = 1'b1;
    tick();
    check("to_err_pulse", 32'(err), 0);
    check("to_idle", 32'(gnt), 0);

    // Asynchronous reset while the access is in WAIT
    eng_lat = 6;
    set_slot(2, {1'b0, 10'h020}, 16'h0000);
    req[2] = 1'b1;
    tick(); tick();
    check("mrst_pre_start", 32'(bus_start), 1);
    rst_n = 1'b0;
    #1;
    check("mrst_gnt", 32'(gnt), 0);
    check("mrst_bus_start", 32'(bus_start), 0);
    check("mrst_bus_addr", 32'(bus_addr), 0);
    req = '0; eng_cnt = 0;
    tick();
    rst_n = 1'b1; done_or = '0;
    repeat (10) tick();
    check("mrst_no_done", 32'(done_or), 0);
    eng_lat = 3;

    // Round-robin from a fresh last_rr: 1, 2, 3, 1
    set_slot(1, {1'b0, 10'h011}, 16'h0000);
    set_slot(2, {1'b0, 10'h012}, 16'h0000);
    set_slot(3, {1'b0, 10'h013}, 16'h0000);
    req[1] = 1'b1; req[2] = 1'b1; req[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done($sformatf("rr%0d", k));
      check($sformatf("rr%0d_done", k), 32'(done), 32'(rr_exp[k]));
      tick();
      check($sformatf("rr%0d_gap", k), 32'(gnt), 0);
      if (k == 3) req = '0;
    end
    tick(); tick();
    check("rr_end_idle", 32'(gnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
